// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its HI/LO busy timer.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // Bit positions in the stall-cause vector.
  localparam int unsigned CAUSE_LOAD_USE = 0;
  localparam int unsigned CAUSE_BR_EX    = 1;
  localparam int unsigned CAUSE_BR_MEM   = 2;
  localparam int unsigned CAUSE_MD_WAIT  = 3;
  localparam int unsigned CAUSE_W        = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// HI/LO occupancy timer: md_busy is high for exactly MD_LAT cycles after a start.
// Registered output; abort clears it on the next edge, and abort beats start.
module hazard_ctrl_md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_abort,
  output logic o_md_busy
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    if (i_abort) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_start) begin
            w_state_nxt = MD_WAIT;
            w_cnt_nxt   = CNT_W'(MD_LAT - 1);
            w_busy_nxt  = 1'b1;
          end
        end
        MD_WAIT: begin
          // A start seen here is illegal upstream and deliberately does not restart.
          if (r_cnt == '0) begin
            w_state_nxt = RUN;
            w_busy_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_md_busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS core: same-cycle stall/flush/PC-select, md_busy registered.
// Priority exc_req > stall > jump; optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_id_branch,
  input  logic       i_id_md_use,
  input  logic       i_jpc_avail,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rw,
  input  logic       i_ex_md_start,
  input  logic       i_mem_mem_read,
  input  logic [4:0] i_mem_rw,
  input  logic       i_exc_req,
  output logic       o_pc_stall,
  output logic       o_if_stall,
  output logic       o_if_flush,
  output logic       o_id_flush,
  output logic       o_ex_flush,
  output logic       o_pc_sel_jpc,
  output logic       o_pc_sel_exc,
  output logic       o_md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
`endif
);

  logic               w_md_busy;
  logic               w_hit_ex;
  logic               w_hit_mem;
  logic [CAUSE_W-1:0] w_cause;
  logic               w_stall;

  hazard_ctrl_md_busy_timer #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_ex_md_start),
    .i_abort   (i_exc_req),
    .o_md_busy (w_md_busy)
  );

  assign w_hit_ex  = i_ex_reg_write && (i_ex_rw != REG_ZERO) &&
                     ((i_id_use_rs && (i_id_rs == i_ex_rw)) ||
                      (i_id_use_rt && (i_id_rt == i_ex_rw)));
  assign w_hit_mem = i_mem_mem_read && (i_mem_rw != REG_ZERO) &&
                     ((i_id_use_rs && (i_id_rs == i_mem_rw)) ||
                      (i_id_use_rt && (i_id_rt == i_mem_rw)));

  // ID-stage branch forwarding only reaches MEM/WB, so EX results and MEM loads must wait.
  always_comb begin
    w_cause                 = '0;
    w_cause[CAUSE_LOAD_USE] = w_hit_ex && i_ex_mem_read;
    w_cause[CAUSE_BR_EX]    = i_id_branch && w_hit_ex;
    w_cause[CAUSE_BR_MEM]   = i_id_branch && w_hit_mem;
    w_cause[CAUSE_MD_WAIT]  = i_id_md_use && w_md_busy;
  end

  assign w_stall = |w_cause;

  always_comb begin
    o_pc_stall   = 1'b0;
    o_if_stall   = 1'b0;
    o_if_flush   = 1'b0;
    o_id_flush   = 1'b0;
    o_ex_flush   = 1'b0;
    o_pc_sel_jpc = 1'b0;
    o_pc_sel_exc = 1'b0;
    if (!i_rst_n) begin
      o_pc_stall = 1'b0;
    end else if (i_exc_req) begin
      o_pc_sel_exc = 1'b1;
      o_if_flush   = 1'b1;
      o_id_flush   = 1'b1;
      o_ex_flush   = 1'b1;
    end else if (w_stall) begin
      o_pc_stall = 1'b1;
      o_if_stall = 1'b1;
      o_id_flush = 1'b1;
    end else begin
      // The delay slot still executes, so a taken jump never flushes IF.
      o_pc_sel_jpc = i_jpc_avail;
    end
  end

  assign o_md_busy = w_md_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall && !i_exc_req && (r_perf_stall_cnt != '1))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (i_exc_req && (r_perf_flush_cnt != '1))
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LAT=4; outputs packed as
// {pc_stall,if_stall,if_flush,id_flush,ex_flush,pc_sel_jpc,pc_sel_exc,md_busy}.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rw, mem_rw;
  logic       id_use_rs, id_use_rt, id_branch, id_md_use, jpc_avail;
  logic       ex_reg_write, ex_mem_read, ex_md_start, mem_mem_read, exc_req;
  logic       pc_stall, if_stall, if_flush, id_flush, ex_flush;
  logic       pc_sel_jpc, pc_sel_exc, md_busy;
  logic [7:0] outs;

  int n_checks = 0;
  int n_errors = 0;
  int n_busy;

  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_STALL = 8'b1101_0000;
  localparam logic [7:0] O_JUMP  = 8'b0000_0100;
  localparam logic [7:0] O_EXC   = 8'b0011_1010;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(6)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_use_rs    (id_use_rs),
    .i_id_use_rt    (id_use_rt),
    .i_id_branch    (id_branch),
    .i_id_md_use    (id_md_use),
    .i_jpc_avail    (jpc_avail),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_rw        (ex_rw),
    .i_ex_md_start  (ex_md_start),
    .i_mem_mem_read (mem_mem_read),
    .i_mem_rw       (mem_rw),
    .i_exc_req      (exc_req),
    .o_pc_stall     (pc_stall),
    .o_if_stall     (if_stall),
    .o_if_flush     (if_flush),
    .o_id_flush     (id_flush),
    .o_ex_flush     (ex_flush),
    .o_pc_sel_jpc   (pc_sel_jpc),
    .o_pc_sel_exc   (pc_sel_exc),
    .o_md_busy      (md_busy)
  );

  assign outs = {pc_stall, if_stall, if_flush, id_flush, ex_flush, pc_sel_jpc, pc_sel_exc, md_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp);
    #1;
    check_eq(tag, {24'd0, outs}, {24'd0, exp});
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rw = '0; mem_rw = '0;
    id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_md_use = 0; jpc_avail = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_md_start = 0; mem_mem_read = 0; exc_req = 0;
  endtask

  // Advance to just after the next rising edge with all inputs idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_reg_write = 1; ex_mem_read = 1; ex_rw = r; id_use_rs = 1; id_rs = r;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    chk_out("reset_idle", O_IDLE);
    set_load_use(5'd5);
    id_md_use = 1; jpc_avail = 1; exc_req = 1;
    chk_out("reset_forced_zero", O_IDLE);
    clr();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Load-use on $5, then released when the load is in MEM.
    set_load_use(5'd5);
    chk_out("load_use_stall", O_STALL);
    cyc();
    mem_mem_read = 1; mem_rw = 5'd5; id_use_rs = 1; id_rs = 5'd5;
    chk_out("load_use_release", O_IDLE);
    cyc();
    set_load_use(5'd0);
    chk_out("load_use_reg0", O_IDLE);
    cyc();
    ex_reg_write = 1; ex_mem_read = 1; ex_rw = 5'd5; id_use_rs = 0; id_rs = 5'd5;
    chk_out("no_use_no_stall", O_IDLE);
    cyc();

    // Branch on ALU result in EX ($8 via rt), then no stall with addi in MEM.
    id_branch = 1; id_use_rs = 1; id_rs = 5'd3; id_use_rt = 1; id_rt = 5'd8;
    ex_reg_write = 1; ex_rw = 5'd8; jpc_avail = 1;
    chk_out("br_ex_stall", O_STALL);
    cyc();
    id_branch = 1; id_use_rt = 1; id_rt = 5'd8; mem_rw = 5'd8; jpc_avail = 1;
    chk_out("br_alu_mem_jump", O_JUMP);
    cyc();
    chk_out("no_jump_idle", O_IDLE);

    // Branch on a load: two stall cycles with jpc_avail ignored, then jump.
    id_branch = 1; id_use_rs = 1; id_rs = 5'd9; jpc_avail = 1;
    ex_reg_write = 1; ex_mem_read = 1; ex_rw = 5'd9;
    chk_out("br_load_stall1", O_STALL);
    cyc();
    id_branch = 1; id_use_rs = 1; id_rs = 5'd9; jpc_avail = 1;
    mem_mem_read = 1; mem_rw = 5'd9;
    chk_out("br_load_stall2", O_STALL);
    cyc();
    id_branch = 1; id_use_rs = 1; id_rs = 5'd9; jpc_avail = 1;
    chk_out("br_load_release", O_JUMP);
    cyc();

    // mul/div: md_busy for 4 cycles, mflo stalled throughout, released on the 5th.
    ex_md_start = 1;
    chk_out("md_start_cycle", O_IDLE);
    cyc();
    for (int i = 0; i < 4; i++) begin
      id_md_use = 1;
      chk_out($sformatf("md_wait_%0d", i), 8'b1101_0001);
      cyc();
    end
    id_md_use = 1;
    chk_out("md_release", O_IDLE);
    cyc();

    // An illegal second start while busy must not extend occupancy.
    ex_md_start = 1;
    cyc();
    n_busy = 0;
    while (md_busy && n_busy < 20) begin
      n_busy++;
      if (n_busy == 1) ex_md_start = 1;
      cyc();
    end
    check_eq("md_no_restart_len", n_busy, 4);

    // Exception during load-use stall while busy count=2.
    ex_md_start = 1;
    cyc();
    cyc();
    set_load_use(5'd7);
    id_md_use = 1; jpc_avail = 1; exc_req = 1;
    chk_out("exc_priority", O_EXC | 8'b0000_0001);
    cyc();
    chk_out("exc_aborts_md", O_IDLE);

    // Exception and start together: no start.
    ex_md_start = 1; exc_req = 1;
    chk_out("exc_and_start", O_EXC);
    cyc();
    id_md_use = 1;
    chk_out("exc_beats_start", O_IDLE);
    cyc();

    // Async reset mid-MD_WAIT.
    ex_md_start = 1;
    cyc();
    chk_out("md_busy_before_rst", 8'b0000_0001);
    id_md_use = 1; set_load_use(5'd4);
    rst_n = 1'b0;
    chk_out("async_rst_zero", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    cyc();
    id_md_use = 1;
    chk_out("post_rst_run", O_IDLE);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
